// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared rasteriser types and screen defaults
package raster_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int COORD_W_DEF  = 16;

    typedef logic signed [COORD_W_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } bbox_iter_state_t;

endpackage

// File: rtl/bbox_clip.sv
// rtl/bbox_clip.sv - combinational signed clamp of a bbox to the screen with empty detect
module bbox_clip #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COORD_W  = 16
) (
    input  logic signed [COORD_W-1:0] x_min,
    input  logic signed [COORD_W-1:0] x_max,
    input  logic signed [COORD_W-1:0] y_min,
    input  logic signed [COORD_W-1:0] y_max,
    output logic        [COORD_W-1:0] cx_min,
    output logic        [COORD_W-1:0] cx_max,
    output logic        [COORD_W-1:0] cy_min,
    output logic        [COORD_W-1:0] cy_max,
    output logic                      empty
);

    // One extra bit keeps every compare free of overflow at the coordinate extremes.
    localparam int EW = COORD_W + 1;
    localparam logic signed [EW-1:0] X_LIM = EW'(SCREEN_W - 1);
    localparam logic signed [EW-1:0] Y_LIM = EW'(SCREEN_H - 1);

    logic signed [EW-1:0] ex_min, ex_max, ey_min, ey_max;
    logic signed [EW-1:0] kx_min, kx_max, ky_min, ky_max;

    // Clamp each edge to the screen, then flag boxes whose clamped range is inverted.
    always_comb begin
        ex_min = {x_min[COORD_W-1], x_min};
        ex_max = {x_max[COORD_W-1], x_max};
        ey_min = {y_min[COORD_W-1], y_min};
        ey_max = {y_max[COORD_W-1], y_max};

        kx_min = ex_min[EW-1] ? '0 : ex_min;
        ky_min = ey_min[EW-1] ? '0 : ey_min;
        kx_max = (ex_max > X_LIM) ? X_LIM : ex_max;
        ky_max = (ey_max > Y_LIM) ? Y_LIM : ey_max;

        empty  = (kx_min > kx_max) || (ky_min > ky_max);

        cx_min = kx_min[COORD_W-1:0];
        cx_max = kx_max[COORD_W-1:0];
        cy_min = ky_min[COORD_W-1:0];
        cy_max = ky_max[COORD_W-1:0];
    end

endmodule

// File: rtl/bbox_pixel_iterator.sv
// rtl/bbox_pixel_iterator.sv - clips a bbox and streams its pixels row-major (optional BBOX_PIX_COUNT_EN pixel counter)
module bbox_pixel_iterator
    import raster_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bbox_valid,
    output logic                      bbox_ready,
    input  logic signed [COORD_W-1:0] bbox_x_min_int,
    input  logic signed [COORD_W-1:0] bbox_x_max_int,
    input  logic signed [COORD_W-1:0] bbox_y_min_int,
    input  logic signed [COORD_W-1:0] bbox_y_max_int,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic        [COORD_W-1:0] pix_x,
    output logic        [COORD_W-1:0] pix_y,
    output logic                      pix_last,
    output logic                      busy,
`ifdef BBOX_PIX_COUNT_EN
    output logic [31:0]               pix_count,
`endif
    output logic                      done
);

    bbox_iter_state_t state_q, state_d;

    logic                      armed_q, armed_d;
    logic signed [COORD_W-1:0] bx_min_q, bx_max_q, by_min_q, by_max_q;
    logic signed [COORD_W-1:0] bx_min_d, bx_max_d, by_min_d, by_max_d;
    logic        [COORD_W-1:0] cx_min_q, cx_max_q, cy_max_q;
    logic        [COORD_W-1:0] cx_min_d, cx_max_d, cy_max_d;
    logic        [COORD_W-1:0] x_q, y_q, x_d, y_d;

    logic        [COORD_W-1:0] clip_cx_min, clip_cx_max, clip_cy_min, clip_cy_max;
    logic                      clip_empty;

`ifdef BBOX_PIX_COUNT_EN
    logic [31:0] count_q, count_d;
    assign pix_count = count_q;
`endif

    bbox_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .COORD_W  (COORD_W)
    ) u_clip (
        .x_min  (bx_min_q),
        .x_max  (bx_max_q),
        .y_min  (by_min_q),
        .y_max  (by_max_q),
        .cx_min (clip_cx_min),
        .cx_max (clip_cx_max),
        .cy_min (clip_cy_min),
        .cy_max (clip_cy_max),
        .empty  (clip_empty)
    );

    // armed_q keeps bbox_ready low while reset is held and for the release edge.
    assign bbox_ready = armed_q && (state_q == IDLE);
    assign pix_valid  = (state_q == SCAN);
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign pix_last   = pix_valid && (x_q == cx_max_q) && (y_q == cy_max_q);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // Next-state logic: accept, clip, scan row-major, pulse done.
    always_comb begin
        state_d  = state_q;
        armed_d  = 1'b1;
        bx_min_d = bx_min_q;
        bx_max_d = bx_max_q;
        by_min_d = by_min_q;
        by_max_d = by_max_q;
        cx_min_d = cx_min_q;
        cx_max_d = cx_max_q;
        cy_max_d = cy_max_q;
        x_d      = x_q;
        y_d      = y_q;
`ifdef BBOX_PIX_COUNT_EN
        count_d  = count_q;
`endif
        case (state_q)
            IDLE: begin
                if (bbox_valid && bbox_ready) begin
                    bx_min_d = bbox_x_min_int;
                    bx_max_d = bbox_x_max_int;
                    by_min_d = bbox_y_min_int;
                    by_max_d = bbox_y_max_int;
`ifdef BBOX_PIX_COUNT_EN
                    count_d  = '0;
`endif
                    state_d  = CLIP;
                end
            end
            CLIP: begin
                if (clip_empty) begin
                    state_d = DONE;
                end else begin
                    cx_min_d = clip_cx_min;
                    cx_max_d = clip_cx_max;
                    cy_max_d = clip_cy_max;
                    x_d      = clip_cx_min;
                    y_d      = clip_cy_min;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (pix_ready) begin
`ifdef BBOX_PIX_COUNT_EN
                    count_d = count_q + 32'd1;
`endif
                    if (x_q < cx_max_q) begin
                        x_d = x_q + 1'b1;
                    end else begin
                        x_d = cx_min_q;
                        y_d = y_q + 1'b1;
                    end
                    if (pix_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any box in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            bx_min_q <= '0;
            bx_max_q <= '0;
            by_min_q <= '0;
            by_max_q <= '0;
            cx_min_q <= '0;
            cx_max_q <= '0;
            cy_max_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
`ifdef BBOX_PIX_COUNT_EN
            count_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            bx_min_q <= bx_min_d;
            bx_max_q <= bx_max_d;
            by_min_q <= by_min_d;
            by_max_q <= by_max_d;
            cx_min_q <= cx_min_d;
            cx_max_q <= cx_max_d;
            cy_max_q <= cy_max_d;
            x_q      <= x_d;
            y_q      <= y_d;
`ifdef BBOX_PIX_COUNT_EN
            count_q  <= count_d;
`endif
        end
    end

endmodule
